// File: rtl/plazer_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : plazer_pkg
// Description : Shared constants and types for the pixel row assembler and
//               the convolution stage that consumes its rows.
// Revision    : 1.0 - initial release
// ============================================================================
package plazer_pkg;

  localparam int ROW_PIXELS = 120;                 // pixels per row
  localparam int PIX_W      = 8;                   // bits per pixel
  localparam int ROW_IDX_W  = 9;                   // row index width, wraps
  localparam int COL_W      = $clog2(ROW_PIXELS);  // column counter width

  typedef logic [PIX_W-1:0]     pixel_t;
  typedef pixel_t [ROW_PIXELS-1:0] row_t;
  typedef logic [COL_W-1:0]     col_t;
  typedef logic [ROW_IDX_W-1:0] row_idx_t;

endpackage
`default_nettype wire

// File: rtl/pixel_row_assembler_row_bank.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : row_bank
// Description : One row store of the double buffer. Holds ROW_PIXELS pixels
//               written one column at a time, the row index captured when
//               the row completes, and a full flag.
// Ports       : clk, rst_n      - clock, async active-low reset
//               i_wr_en/i_wr_col/i_wr_data - single pixel write
//               i_set_full/i_set_idx - mark row complete, capture its index
//               i_clr_full      - consumer has taken the row
//               o_row/o_idx/o_full - stored row, its index, full flag
// Revision    : 1.0 - initial release
// ============================================================================
module row_bank
  import plazer_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     i_wr_en,
  input  col_t     i_wr_col,
  input  pixel_t   i_wr_data,
  input  logic     i_set_full,
  input  row_idx_t i_set_idx,
  input  logic     i_clr_full,
  output row_t     o_row,
  output row_idx_t o_idx,
  output logic     o_full
);

  row_t     r_row;
  row_idx_t r_idx;
  logic     r_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row  <= '0;
      r_idx  <= '0;
      r_full <= 1'b0;
    end else begin
      if (i_wr_en) begin
        r_row[i_wr_col] <= i_wr_data;
      end
      if (i_set_full) begin
        r_full <= 1'b1;
        r_idx  <= i_set_idx;
      end else if (i_clr_full) begin
        // Set and clear never target the same bank in one cycle: a bank is
        // only written while empty and only drained while full.
        r_full <= 1'b0;
      end
    end
  end

  assign o_row  = r_row;
  assign o_idx  = r_idx;
  assign o_full = r_full;

endmodule
`default_nettype wire

// File: rtl/pixel_row_assembler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : pixel_row_assembler
// Description : Collects a serial pixel stream into complete rows and hands
//               each row out in parallel with a valid/ready handshake. Two
//               row banks let one row fill while the other is held.
// Ports       : clk, rst_n                  - clock, async active-low reset
//               i_pix_data/i_pix_valid/i_pix_sol/i_pix_sof, o_pix_ready
//                                            - pixel input stream
//               o_row_data/o_row_index/o_row_valid, i_row_ready
//                                            - parallel row output
//               o_sol_err                    - sticky truncated-row flag
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_row_assembler
  import plazer_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  pixel_t   i_pix_data,
  input  logic     i_pix_valid,
  input  logic     i_pix_sol,
  input  logic     i_pix_sof,
  output logic     o_pix_ready,
  output row_t     o_row_data,
  output row_idx_t o_row_index,
  output logic     o_row_valid,
  input  logic     i_row_ready,
  output logic     o_sol_err
);

  logic     r_wr_bank;
  logic     r_rd_bank;
  col_t     r_col;
  row_idx_t r_row_cnt;
  logic     r_sol_err;

  logic     w_full [2];
  row_t     w_row  [2];
  row_idx_t w_idx  [2];

  logic w_accept;
  logic w_sol;
  logic w_last;
  logic w_complete;
  logic w_take;
  col_t w_wr_col;

  assign o_pix_ready = ~w_full[r_wr_bank];
  assign w_accept    = i_pix_valid & o_pix_ready;
  // A frame start is always also a row start.
  assign w_sol       = i_pix_sol | i_pix_sof;
  assign w_last      = (r_col == col_t'(ROW_PIXELS - 1));
  // A row start on the last column begins a new one-pixel row instead.
  assign w_complete  = w_accept & ~w_sol & w_last;
  assign w_take      = o_row_valid & i_row_ready;
  assign w_wr_col    = w_sol ? '0 : r_col;

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    row_bank u_bank (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_wr_en    (w_accept   && (r_wr_bank == 1'(gi))),
      .i_wr_col   (w_wr_col),
      .i_wr_data  (i_pix_data),
      .i_set_full (w_complete && (r_wr_bank == 1'(gi))),
      .i_set_idx  (r_row_cnt),
      .i_clr_full (w_take     && (r_rd_bank == 1'(gi))),
      .o_row      (w_row[gi]),
      .o_idx      (w_idx[gi]),
      .o_full     (w_full[gi])
    );
  end

  assign o_row_valid = w_full[r_rd_bank];
  assign o_row_data  = w_row[r_rd_bank];
  assign o_row_index = w_idx[r_rd_bank];
  assign o_sol_err   = r_sol_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_col     <= '0;
      r_row_cnt <= '0;
      r_sol_err <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_sol) begin
          // Pixel lands in column 0; anything partially collected is
          // abandoned and flagged.
          r_col <= col_t'(1);
          if (r_col != '0) begin
            r_sol_err <= 1'b1;
          end
          if (i_pix_sof) begin
            r_row_cnt <= '0;
          end
        end else if (w_last) begin
          r_col     <= '0;
          r_row_cnt <= r_row_cnt + row_idx_t'(1);
          r_wr_bank <= ~r_wr_bank;
        end else begin
          r_col <= r_col + col_t'(1);
        end
      end
      if (w_take) begin
        r_rd_bank <= ~r_rd_bank;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pixel_row_assembler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_pixel_row_assembler
// Description : Self-checking bench for pixel_row_assembler. A row-level
//               model (queue of held rows) is compared against the DUT every
//               cycle; directed tests add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_row_assembler;
  import plazer_pkg::*;

  logic     clk = 1'b0;
  logic     rst_n = 1'b0;
  pixel_t   pix_data = '0;
  logic     pix_valid = 1'b0;
  logic     pix_sol = 1'b0;
  logic     pix_sof = 1'b0;
  logic     row_ready = 1'b0;
  logic     pix_ready;
  row_t     row_data;
  row_idx_t row_index;
  logic     row_valid;
  logic     sol_err;

  int checks = 0;
  int errors = 0;
  int stalls = 0;

  pixel_row_assembler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_pix_data  (pix_data),
    .i_pix_valid (pix_valid),
    .i_pix_sol   (pix_sol),
    .i_pix_sof   (pix_sof),
    .o_pix_ready (pix_ready),
    .o_row_data  (row_data),
    .o_row_index (row_index),
    .o_row_valid (row_valid),
    .i_row_ready (row_ready),
    .o_sol_err   (sol_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- row-level model ----------------
  typedef struct {
    row_t     d;
    row_idx_t i;
  } ent_t;

  ent_t     q[$];
  ent_t     m_ent;
  row_t     m_cur;
  int       m_col;
  row_idx_t m_row;
  logic     m_err;
  bit       m_acc;
  bit       m_con;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_cur = '0;
      m_col = 0;
      m_row = '0;
      m_err = 1'b0;
    end else begin
      m_acc = pix_valid && (q.size() < 2);
      m_con = (q.size() > 0) && row_ready;
      if (m_con) void'(q.pop_front());
      if (m_acc) begin
        if (pix_sol || pix_sof) begin
          if (m_col != 0) m_err = 1'b1;
          if (pix_sof) m_row = '0;
          m_cur[0] = pix_data;
          m_col = 1;
        end else begin
          m_cur[m_col] = pix_data;
          if (m_col == ROW_PIXELS - 1) begin
            m_ent.d = m_cur;
            m_ent.i = m_row;
            q.push_back(m_ent);
            m_row = m_row + 1'b1;
            m_col = 0;
          end else begin
            m_col++;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("pix_ready", 32'(pix_ready), 32'(q.size() < 2));
      chk("row_valid", 32'(row_valid), 32'(q.size() > 0));
      chk("sol_err", 32'(sol_err), 32'(m_err));
      if (q.size() > 0) begin
        checks++;
        if (row_data !== q[0].d) begin
          errors++;
          $display("FAIL row_data actual=%h required=%h", row_data, q[0].d);
        end
        chk("row_index", 32'(row_index), 32'(q[0].i));
      end
    end
  end

  // ---------------- stimulus ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input pixel_t d, input logic sol, input logic sof);
    int n = 0;
    bit acc = 1'b0;
    pix_data = d; pix_sol = sol; pix_sof = sof; pix_valid = 1'b1;
    while (!acc && n < 300) begin
      @(negedge clk);
      acc = pix_ready;
      if (!acc) stalls++;
      @(posedge clk);
      #1;
      n++;
    end
    pix_valid = 1'b0; pix_sol = 1'b0; pix_sof = 1'b0;
    if (!acc) chk("send_timeout", 32'(acc), 32'd1);
  endtask

  task automatic send_row(input pixel_t base, input logic sol, input logic sof,
                          input bit chk_on, input int exp_idx);
    for (int c = 0; c < ROW_PIXELS; c++)
      send(pixel_t'(int'(base) + c), (c == 0) ? sol : 1'b0, (c == 0) ? sof : 1'b0);
    if (chk_on) begin
      @(negedge clk);
      chk("lit_row_valid", 32'(row_valid), 32'd1);
      chk("lit_row_index", 32'(row_index), 32'(exp_idx));
      chk("lit_row_pix0", 32'(row_data[0]), 32'(base));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int bad;
    // Reset state
    #12;
    chk("rst_row_valid", 32'(row_valid), 32'd0);
    chk("rst_pix_ready", 32'(pix_ready), 32'd1);
    chk("rst_row_data_zero", 32'(row_data == '0), 32'd1);
    chk("rst_sol_err", 32'(sol_err), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single ramp row 0..119
    row_ready = 1'b1;
    send_row(8'd0, 1'b0, 1'b1, 1'b0, 0);
    @(negedge clk);
    chk("t1_valid", 32'(row_valid), 32'd1);
    chk("t1_index", 32'(row_index), 32'd0);
    bad = 0;
    for (int k = 0; k < ROW_PIXELS; k++)
      if (row_data[k] !== pixel_t'(k)) bad++;
    chk("t1_ramp_bad_pixels", 32'(bad), 32'd0);
    @(negedge clk);
    chk("t1_valid_fall", 32'(row_valid), 32'd0);
    @(posedge clk); #1;

    // Three streamed rows, consumer always ready
    stalls = 0;
    for (int r = 0; r < 3; r++)
      send_row(pixel_t'(r * 16), 1'b0, (r == 0), 1'b1, r);
    chk("t2_no_stall", 32'(stalls), 32'd0);

    // Both banks fill while consumer stalls
    row_ready = 1'b0;
    send_row(8'h30, 1'b0, 1'b1, 1'b0, 0);
    send_row(8'h50, 1'b0, 1'b0, 1'b0, 0);
    @(negedge clk);
    chk("t3_ready_low", 32'(pix_ready), 32'd0);
    chk("t3_row0_pix0", 32'(row_data[0]), 32'h30);
    chk("t3_row0_pix119", 32'(row_data[119]), 32'hA7);
    chk("t3_row0_index", 32'(row_index), 32'd0);
    @(posedge clk); #1;
    row_ready = 1'b1;
    @(posedge clk); #1;
    row_ready = 1'b0;
    @(negedge clk);
    chk("t3_row1_valid", 32'(row_valid), 32'd1);
    chk("t3_row1_pix0", 32'(row_data[0]), 32'h50);
    chk("t3_row1_index", 32'(row_index), 32'd1);
    chk("t3_ready_back", 32'(pix_ready), 32'd1);
    @(posedge clk); #1;
    row_ready = 1'b1;
    @(posedge clk); #1;

    // Early row start truncates a partial row
    for (int i = 0; i < 50; i++)
      send(8'hAA, 1'b0, (i == 0));
    send_row(8'd100, 1'b1, 1'b0, 1'b1, 0);
    chk("t4_sol_err", 32'(sol_err), 32'd1);

    // Frame restart and row index wrap
    send_row(8'h01, 1'b0, 1'b1, 1'b1, 0);
    for (int r = 1; r < 5; r++)
      send_row(pixel_t'(r), 1'b0, 1'b0, 1'b1, r);
    send_row(8'hC0, 1'b0, 1'b1, 1'b1, 0);
    for (int r = 1; r < 511; r++)
      send_row(pixel_t'(r), 1'b0, 1'b0, 1'b0, 0);
    send_row(8'hE0, 1'b0, 1'b0, 1'b1, 511);
    send_row(8'hE1, 1'b0, 1'b0, 1'b1, 0);

    // Asynchronous reset with a held row and a partial row
    row_ready = 1'b0;
    send_row(8'h10, 1'b0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 60; i++)
      send(8'h55, 1'b0, 1'b0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(row_valid), 32'd0);
    chk("t6_rst_ready", 32'(pix_ready), 32'd1);
    chk("t6_rst_data_zero", 32'(row_data == '0), 32'd1);
    chk("t6_rst_sol_err", 32'(sol_err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    row_ready = 1'b1;
    send_row(8'h33, 1'b0, 1'b0, 1'b1, 0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
